// File: rtl/priority_encoder_n_pkg.sv
// Shared definitions for the N-input registered priority encoder:
// mode encodings, output-register occupancy states and an index-width helper.
package priority_encoder_n_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_state_e;

  // Ceiling log2 for tools that lack $clog2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/priority_encoder_n_prio_search.sv
// Combinational descending search with wrap: starting at start_i and moving
// toward 0, then wrapping to N-1, report the first set request bit.
module prio_search #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    // NOTE: every combinational output gets a default before the search loop,
    // otherwise the paths where no bit is set would infer latches.
    found_o = 1'b0;
    idx_o   = '0;
    // Walk from the farthest offset to the nearest so the nearest set bit
    // (offset 0 = start_i) is the last to be written and wins.
    for (int o = N - 1; o >= 0; o--) begin
      int c;
      c = (int'(start_i) >= o) ? int'(start_i) - o : int'(start_i) + N - o;
      if (req_i[c[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/priority_encoder_n.sv
// Registered N-input priority encoder with a one-entry valid/ready output
// stage; fixed (MSB-first) or round-robin arbitration selected by MODE.
module priority_encoder_n
  import priority_encoder_n_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  output logic         y,
  output logic [W-1:0] z,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  occ_state_e   state_q, state_d;
  logic [W-1:0] z_q, z_d;
  logic [W-1:0] p_q, p_d;

  logic [W-1:0] search_start;
  logic         found;
  logic [W-1:0] win_idx;
  logic         load;

  assign y = |x;

  // Fixed mode always searches from the top index; the pointer is only
  // consulted in round-robin mode.
  assign search_start = (MODE == MODE_RR) ? p_q : LAST_IDX;

  prio_search #(
    .N(N),
    .W(W)
  ) u_search (
    .req_i   (x),
    .start_i (search_start),
    .found_o (found),
    .idx_o   (win_idx)
  );

  assign load = ((state_q == EMPTY) || out_ready) && found;

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    p_d     = p_q;
    if (load) begin
      state_d = FULL;
      z_d     = win_idx;
      if (MODE == MODE_RR) begin
        // Next search begins just below the granted index, wrapping to N-1
        // rather than 2^W-1 so non-power-of-two N never yields an invalid index.
        p_d = (win_idx == '0) ? LAST_IDX : win_idx - W'(1);
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      z_q     <= '0;
      p_q     <= LAST_IDX;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      p_q     <= p_d;
    end
  end

  assign z         = z_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_priority_encoder_n.sv
// Directed bench for priority_encoder_n: fixed mode (N=8), round-robin (N=8)
// and round-robin with non-power-of-two width (N=5), sharing clock and reset.
module tb_priority_encoder_n;

  logic clk;
  logic rst;

  logic [7:0] x_f,   x_r;
  logic [4:0] x_5;
  logic       rdy_f, rdy_r, rdy_5;
  logic       y_f,   y_r,   y_5;
  logic [2:0] z_f,   z_r,   z_5;
  logic       vld_f, vld_r, vld_5;

  int nchecks = 0;
  int nerrors = 0;

  priority_encoder_n #(.N(8), .MODE(0)) dut_fixed (
    .clk(clk), .rst(rst), .x(x_f), .y(y_f), .z(z_f),
    .out_valid(vld_f), .out_ready(rdy_f)
  );

  priority_encoder_n #(.N(8), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .x(x_r), .y(y_r), .z(z_r),
    .out_valid(vld_r), .out_ready(rdy_r)
  );

  priority_encoder_n #(.N(5), .MODE(1)) dut_rr5 (
    .clk(clk), .rst(rst), .x(x_5), .y(y_5), .z(z_5),
    .out_valid(vld_5), .out_ready(rdy_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    x_f   = 8'h00; x_r = 8'h00; x_5 = 5'b00000;
    rdy_f = 1'b0;  rdy_r = 1'b0; rdy_5 = 1'b0;

    // 1. Reset state and idle
    step();
    step();
    check("rst_z",     z_f,   0);
    check("rst_valid", vld_f, 0);
    check("rst_y",     y_f,   0);
    check("rst_z_rr5", z_5,   0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_valid_%0d", i), vld_f, 0);
    end

    // 2. Fixed priority, highest index wins
    rdy_f = 1'b1;
    x_f   = 8'b0010_0110;
    #1 check("fix_y_comb", y_f, 1);
    step();
    check("fix_z5",     z_f,   5);
    check("fix_v5",     vld_f, 1);
    check("fix_y5",     y_f,   1);
    x_f = 8'b0000_0110;
    step();
    check("fix_z2", z_f, 2);
    check("fix_y2", y_f, 1);
    x_f = 8'b0000_0001;
    step();
    check("fix_z0", z_f, 0);
    check("fix_y0", y_f, 1);
    x_f = 8'h00;
    step();
    check("fix_drain_valid", vld_f, 0);
    check("fix_drain_z",     z_f,   0);

    // 3. Round-robin, all requests held: 7..0 then wrap to 7, no gaps
    rdy_r = 1'b1;
    x_r   = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rr_seq_z_%0d", i), z_r, (i < 8) ? 7 - i : 7);
      check($sformatf("rr_seq_v_%0d", i), vld_r, 1);
    end
    x_r = 8'h00;
    step();
    check("rr_drain_valid", vld_r, 0);
    check("rr_drain_z_hold", z_r, 7);

    // 4. Backpressure: pointer is 6, bit 4 alone wins
    x_r = 8'h10;
    step();
    check("bp_load_z", z_r, 4);
    rdy_r = 1'b0;
    x_r   = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold_z_%0d", i), z_r,   4);
      check($sformatf("bp_hold_v_%0d", i), vld_r, 1);
    end
    rdy_r = 1'b1;
    step();
    check("bp_release_z", z_r,   7);
    check("bp_release_v", vld_r, 1);
    x_r = 8'h00;
    step();
    check("bp_drain_valid", vld_r, 0);

    // 5. N=5 round-robin: pointer wraps 0 -> 4, never beyond N-1
    rdy_5 = 1'b1;
    x_5   = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr5_z_%0d", i), z_5, (i % 2 == 0) ? 4 : 0);
      check($sformatf("rr5_range_%0d", i), (z_5 <= 3'd4), 1);
    end
    x_5 = 5'b00000;
    step();
    check("rr5_drain_valid", vld_5, 0);

    // 6. Asynchronous reset while FULL; pointer restarts at N-1
    x_r = 8'h40;
    step();
    check("arst_pre_z", z_r,   6);
    check("arst_pre_v", vld_r, 1);
    rdy_r = 1'b0;
    x_r   = 8'b0100_0001;
    #2 rst = 1'b1;
    #1;
    check("arst_z",     z_r,   0);
    check("arst_valid", vld_r, 0);
    check("arst_y",     y_r,   1);
    #2 rst = 1'b0;
    rdy_r = 1'b1;
    step();
    check("arst_first_z", z_r,   6);
    check("arst_first_v", vld_r, 1);
    step();
    check("arst_second_z", z_r, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
